// File: rtl/bt_word_decoder.sv
// Serial balanced-ternary word decoder: one trit per cycle, Horner accumulation, valid/ready on both sides.
// Optional: define BT_DEC_ERRCNT_EN to add a saturating err_count of words completed with an illegal trit.
module bt_word_decoder #(
  parameter int NTRITS = 4,
  parameter int OUT_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*NTRITS-1:0] in_word,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_value,
  output logic                out_illegal,
  output logic                busy
`ifdef BT_DEC_ERRCNT_EN
  , output logic [7:0]        err_count
`endif
);

  localparam int CNT_W = (NTRITS > 1) ? $clog2(NTRITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic [2*NTRITS-1:0]       r_word;
  logic [CNT_W-1:0]          r_cnt;
  logic signed [OUT_W-1:0]   r_acc;
  logic                      r_illegal;
  logic [OUT_W-1:0]          r_out_value;
  logic                      r_out_illegal;

  logic [1:0]                w_pair;
  logic                      w_pair_illegal;
  logic signed [OUT_W-1:0]   w_trit;
  logic signed [OUT_W-1:0]   w_acc_next;
  logic                      w_last;
  logic                      w_illegal_next;

  always_comb begin
    w_pair = '0;
    for (int unsigned k = 0; k < NTRITS; k++) begin
      if (r_cnt == CNT_W'(k)) w_pair = r_word[2*k +: 2];
    end
  end

  always_comb begin
    w_trit = '0;
    case (w_pair)
      2'b01:   w_trit = '1;
      2'b10:   w_trit = OUT_W'(1);
      default: w_trit = '0;
    endcase
    w_pair_illegal = (w_pair == 2'b00);
    // 3*acc done at OUT_W bits: identical to the OUT_W+2-bit product truncated
    w_acc_next     = r_acc + (r_acc <<< 1) + w_trit;
    w_last         = (r_cnt == CNT_W'(NTRITS - 1));
    w_illegal_next = r_illegal | w_pair_illegal;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next_state = S_SHIFT;
      S_SHIFT: if (w_last)    w_next_state = S_DONE;
      S_DONE:  if (out_ready) w_next_state = S_IDLE;
      default:                w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_word        <= '0;
      r_cnt         <= '0;
      r_acc         <= '0;
      r_illegal     <= 1'b0;
      r_out_value   <= '0;
      r_out_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_word    <= in_word;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_acc     <= w_acc_next;
          r_illegal <= w_illegal_next;
          r_cnt     <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_out_value   <= w_acc_next;
            r_out_illegal <= w_illegal_next;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BT_DEC_ERRCNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_count <= '0;
    end else if (r_state == S_SHIFT && w_last && w_illegal_next && r_err_count != 8'hFF) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`endif

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign out_value   = r_out_value;
  assign out_illegal = r_out_illegal;

endmodule

// File: tb/tb_bt_word_decoder.sv
// Scoreboard bench for bt_word_decoder: stimulus pushes expected results, a negedge monitor pops on each output handshake.
module tb_bt_word_decoder;

  localparam int NTRITS = 4;
  localparam int OUT_W  = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [2*NTRITS-1:0] in_word;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_W-1:0]    out_value;
  logic                out_illegal;
  logic                busy;
`ifdef BT_DEC_ERRCNT_EN
  logic [7:0]          err_count;
`endif

  typedef struct packed {
    logic [OUT_W-1:0] v;
    logic             ill;
  } exp_t;

  exp_t        sb[$];
  int unsigned hs[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  bt_word_decoder #(.NTRITS(NTRITS), .OUT_W(OUT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_word     (in_word),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_value   (out_value),
    .out_illegal (out_illegal),
    .busy        (busy)
`ifdef BT_DEC_ERRCNT_EN
    , .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output is compared against the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        exp_t e;
        hs.push_back(cyc);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got 0x%0h expected none", out_value);
        end else begin
          e = sb.pop_front();
          check("out_value", 32'(out_value), 32'(e.v));
          check("out_illegal", 32'(out_illegal), 32'(e.ill));
        end
      end
    end
  end

  // Leaves in_valid high after the accepting edge; caller decides when to drop it
  task automatic send(input logic [7:0] w, input logic [OUT_W-1:0] v, input logic ill, input bit push);
    int unsigned t = 0;
    in_word  = w;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (in_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=%b expected 1", in_ready);
    end else if (push) begin
      sb.push_back(exp_t'{v: v, ill: ill});
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int unsigned t = 0;
    while (sb.size() > 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    int unsigned t;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_value", 32'(out_value), 0);
    check("rst_out_illegal", 32'(out_illegal), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single word with latency check: 0xB7 -> -8
    send(8'hB7, 8'hF8, 1'b0, 1'b1);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    check("lat_out_valid_e3", 32'(out_valid), 0);
    check("lat_busy_e3", 32'(busy), 1);
    check("lat_in_ready_e3", 32'(in_ready), 0);
    @(posedge clk); #1;
    check("lat_out_valid_e4", 32'(out_valid), 1);
    @(posedge clk); #1;
    check("post_hs_out_valid", 32'(out_valid), 0);
    check("post_hs_in_ready", 32'(in_ready), 1);

    // Back-to-back with in_valid held
    hs.delete();
    send(8'hEB, 8'd12, 1'b0, 1'b1);
    send(8'h7B, 8'd8,  1'b0, 1'b1);
    send(8'hFF, 8'd0,  1'b0, 1'b1);
    in_valid = 1'b0;
    t = 0;
    while (hs.size() < 3 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("b2b_handshakes", hs.size(), 3);
    if (hs.size() >= 3) begin
      check("b2b_period_1", hs[1] - hs[0], NTRITS + 2);
      check("b2b_period_2", hs[2] - hs[1], NTRITS + 2);
    end

    // Extremes
    send(8'hAA, 8'h28, 1'b0, 1'b1);
    in_valid = 1'b0;
    send(8'h55, 8'hD8, 1'b0, 1'b1);
    in_valid = 1'b0;
    drain();

    // Illegal pair
    send(8'h3F, 8'h00, 1'b1, 1'b1);
    in_valid = 1'b0;
    drain();
`ifdef BT_DEC_ERRCNT_EN
    check("err_count_one", 32'(err_count), 1);
`endif

    // Backpressure: 0x9E -> 27-3+1 = 25
    out_ready = 1'b0;
    send(8'h9E, 8'h19, 1'b0, 1'b1);
    in_valid = 1'b0;
    in_word  = 8'h55;
    t = 0;
    while (out_valid !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_out_value", 32'(out_value), 32'h19);
      check("bp_in_ready", 32'(in_ready), 0);
      in_word = 8'(8'h11 * (i + 1));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", 32'(out_valid), 0);
    drain();

    // Reset during the second SHIFT cycle discards the word
    send(8'hB7, 8'h00, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready), 1);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_out_value", 32'(out_value), 0);
    check("mid_rst_out_illegal", 32'(out_illegal), 0);
`ifdef BT_DEC_ERRCNT_EN
    check("mid_rst_err_count", 32'(err_count), 0);
`endif
    send(8'hEB, 8'd12, 1'b0, 1'b1);
    in_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bt_word_decoder.md
Name: bt_word_decoder

Overview:
Sequential decoder for the 2-bit-per-trit balanced-ternary words produced by the TT3 balanced-ternary calculator output bus. It converts one NTRITS-trit word into a signed two's-complement integer, one trit per cycle, using Horner accumulation. It sits downstream of the calculator core, feeding the binary display and checker logic through a valid/ready interface, and flags illegal trit codes.

Parameters:
NTRITS, 4, trits per input word; the input is 2*NTRITS bits wide.
OUT_W, 8, signed output width; must be at least ceil(log2(3^NTRITS))+1, giving a range of ±(3^NTRITS-1)/2.

Ports:
clk  input  1  sole clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_word is valid
in_ready  output  1  decoder can accept a word
in_word  input  2*NTRITS  encoded word; pair k = bits[2k+1:2k]
out_valid  output  1  out_value and out_illegal are valid
out_ready  input  1  consumer accepts the result
out_value  output  OUT_W  signed decoded value
out_illegal  output  1  word contained at least one 00 pair
busy  output  1  high in SHIFT or DONE

Behaviour:
- Trit code per pair: 01 = -1, 11 = 0, 10 = +1, 00 = illegal (treated as 0, sets illegal flag).
- Weights: pair k has weight 3^(NTRITS-1-k), so pair 0 (bits[1:0]) is the most significant trit. Example: 0xB7 decodes to -8.
- FSM states and transitions:
  - IDLE: in_ready=1. On an edge with in_valid=1: capture in_word, clear acc, cnt and illegal, then go to SHIFT.
  - SHIFT: in_ready=0. Each edge performs acc <= 3*acc + trit(pair cnt), ORs the pair's illegal status into the flag, and increments cnt. The edge that processes cnt == NTRITS-1 moves to DONE and sets out_valid=1.
  - DONE: out_valid=1 and outputs are held stable. On an edge with out_ready=1, clear out_valid and go to IDLE.
- Latency: an accept at edge E0 gives out_valid visible after edge E0+NTRITS.
  - No bypass of IDLE, so in_ready re-rises one cycle after the output handshake.
  - Throughput is one word per NTRITS+2 cycles with out_ready held at 1.
- Arithmetic: acc is signed OUT_W bits, and 3*acc is computed in OUT_W+2 bits and truncated. With a legal OUT_W, no overflow is reachable.
- in_word is ignored outside IDLE; the captured copy is used, so input changes during SHIFT have no effect.
- out_valid is never deasserted without an out_ready handshake.
- out_value and out_illegal hold their last values in IDLE and are meaningful only while out_valid=1.
- Reset (any state, including mid-SHIFT or DONE): next state IDLE.
  - in_ready=1 in the cycle after reset.
  - out_valid=0, busy=0, out_value=0, out_illegal=0; acc, cnt and the captured word cleared.
  - An in-flight word is discarded.
- Reset and in_valid asserted together: reset wins and the word is not accepted.

Optional Feature:
BT_DEC_ERRCNT_EN:
- Defined: adds output port err_count [7:0], a saturating count (stops at 255) of words completed with out_illegal=1. It increments on the SHIFT-to-DONE edge and is cleared only by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then drive in_word=0xB7 with in_valid pulsed and out_ready=1 -> out_valid after 4 edges; out_value=0xF8 (-8), out_illegal=0; in_ready returns 1.
- Back-to-back words 0xEB, 0x7B, 0xFF with in_valid held -> out_value 12, 8, 0 in order, each NTRITS+2 cycles apart, none dropped.
- Extremes 0xAA and 0x55 -> +40 (0x28) and -40 (0xD8).
- Illegal 0x3F (pair 3 = 00) -> out_value=0, out_illegal=1; with BT_DEC_ERRCNT_EN defined, err_count=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_value stable and in_ready=0 throughout; the in_word change is ignored; the result is released on out_ready.
- Reset asserted on the second SHIFT cycle of 0xB7 -> next cycle IDLE with all outputs zero; a following 0xEB decodes to 12.
